// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - rx_state_t       : receiver FSM state encoding
//   - UART_IDLE/START/STOP : serial line levels
//   - even_parity()    : even parity (XOR of the data bits), up to
//                        PARITY_MAX_WIDTH bits. Narrower words are zero-extended
//                        by the caller, which leaves the XOR unchanged.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4,
    S_BREAK_WAIT = 3'd5
  } rx_state_t;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  localparam int PARITY_MAX_WIDTH = 32;

  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Front end of the UART receiver: brings the asynchronous serial line into the
// clk domain through two flops, detects the 1->0 transition that marks a start
// bit, and produces the bit value the FSM should use when it samples.
//
// Optional feature (macro UART_RX_MAJORITY_VOTE_EN):
//   o_rx_bit is the 2-of-3 majority of the synchronised line in the current
//   cycle and the two cycles before it. The FSM asserts its decision one cycle
//   after the bit centre, so the three votes fall at centre-1, centre, centre+1.
//   Without the macro, o_rx_bit is simply the synchronised line.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   i_rx     in   raw asynchronous serial line (idles high)
//   o_rx_s   out  synchronised line
//   o_fall   out  1 for one cycle when o_rx_s goes 1 -> 0
//   o_rx_bit out  bit value to use at a sample decision
// -----------------------------------------------------------------------------
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall,
  output logic o_rx_bit
);

  logic r_meta;     // first synchroniser flop, may go metastable
  logic r_rx_s;     // second synchroniser flop, safe to use
  logic r_rx_prev;  // r_rx_s one cycle ago, for edge detection

  // Flops reset to the idle line level so leaving reset never looks like a
  // start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta    <= UART_IDLE;
      r_rx_s    <= UART_IDLE;
      r_rx_prev <= UART_IDLE;
    end else begin
      r_meta    <= i_rx;
      r_rx_s    <= r_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign o_rx_s = r_rx_s;
  assign o_fall = r_rx_prev & ~r_rx_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_rx_prev2;  // r_rx_s two cycles ago

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_prev2 <= UART_IDLE;
    end else begin
      r_rx_prev2 <= r_rx_prev;
    end
  end

  assign o_rx_bit = (r_rx_s & r_rx_prev) | (r_rx_s & r_rx_prev2) |
                    (r_rx_prev & r_rx_prev2);
`else
  assign o_rx_bit = r_rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART serial receiver. Frame: start (0), WORD_LENGTH data bits LSB first,
// one even-parity bit, stop (1). Bit timing is recovered from the start-bit
// edge and each bit is taken at its centre. A received frame is held for the
// APB side until Rx_RD; a frame that arrives while one is still held is
// dropped and flagged as overrun. err_ack pulses toward the transmitter for
// one cycle whenever a frame has a parity or framing error.
//
// Optional feature (macro UART_RX_MAJORITY_VOTE_EN):
//   every bit, including the start bit, is the 2-of-3 majority of samples at
//   centre-1, centre, centre+1; the decision is taken at centre+1. The bit
//   counter is untouched, so the bit period does not change.
//
// Parameters:
//   WORD_LENGTH  data bits per frame (2..32)
//   CLKS_PER_BIT clk cycles per bit; >= 4, or >= 8 with the voter enabled
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   UART_Rx_IN     in   asynchronous serial line, idles high
//   Rx_DATA        out  last received word
//   Rx_VALID       out  Rx_DATA and the error flags hold an unread frame
//   Rx_RD          in   one-cycle read strobe, consumes the held frame
//   Rx_PARITY_ERR  out  parity mismatch on the held frame
//   Rx_FRAME_ERR   out  stop bit sampled as 0 on the held frame
//   Rx_OVERRUN     out  a frame was lost while Rx_VALID was set
//   err_ack        out  one-cycle pulse on a parity or framing error
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   UART_Rx_IN,
  output logic [WORD_LENGTH-1:0] Rx_DATA,
  output logic                   Rx_VALID,
  input  logic                   Rx_RD,
  output logic                   Rx_PARITY_ERR,
  output logic                   Rx_FRAME_ERR,
  output logic                   Rx_OVERRUN,
  output logic                   err_ack
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = $clog2(WORD_LENGTH + 1);

  // Counter values at which a bit centre is reached: half a bit after the
  // start edge, then a full bit period after each previous centre.
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] LAST_BIT = DW'(WORD_LENGTH - 1);

  // ---------------------------------------------------------------------------
  // Line front end
  // ---------------------------------------------------------------------------
  logic w_rx_s;
  logic w_fall;
  logic w_rx_bit;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_rx     (UART_Rx_IN),
    .o_rx_s   (w_rx_s),
    .o_fall   (w_fall),
    .o_rx_bit (w_rx_bit)
  );

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  rx_state_t r_state;
  rx_state_t w_next_state;

  logic [CW-1:0]          r_clk_cnt;  // cycles since last bit centre
  logic [DW-1:0]          r_bit_cnt;  // data bits taken so far
  logic [WORD_LENGTH-1:0] r_shift;    // data bits, bit i lands in position i
  logic                   r_perr;     // parity result of the frame in flight

  logic [WORD_LENGTH-1:0] r_rx_data;
  logic                   r_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_err_ack;

  logic w_tick;       // bit centre reached this cycle
  logic w_decide;     // the bit value is taken this cycle
  logic w_active;     // a frame is being timed
  logic w_bit_clr;
  logic w_shift_en;
  logic w_parity_en;
  logic w_commit;
  logic w_ferr;

  // ---------------------------------------------------------------------------
  // Bit-centre decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      S_START:                  w_tick = (r_clk_cnt == HALF_M1);
      S_DATA, S_PARITY, S_STOP: w_tick = (r_clk_cnt == FULL_M1);
      default:                  w_tick = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The voter needs the sample one cycle past the centre, so the decision
  // trails the centre tick by a cycle while the counter keeps its reference.
  logic r_tick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= w_tick;
    end
  end

  assign w_decide = r_tick_d;
`else
  assign w_decide = w_tick;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_next_state = S_START;
      end
      S_START: begin
        // A start bit that is high again at its centre was a glitch.
        if (w_decide) w_next_state = (w_rx_bit == UART_START) ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        if (w_decide && (r_bit_cnt == LAST_BIT)) w_next_state = S_PARITY;
      end
      S_PARITY: begin
        if (w_decide) w_next_state = S_STOP;
      end
      S_STOP: begin
        // A low stop bit may be the start of a break; wait it out before
        // looking for another start edge.
        if (w_decide) w_next_state = (w_rx_bit == UART_STOP) ? S_IDLE : S_BREAK_WAIT;
      end
      S_BREAK_WAIT: begin
        if (w_rx_s == UART_IDLE) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (datapath strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_active    = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_parity_en = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_START: begin
        w_active  = 1'b1;
        w_bit_clr = w_decide;
      end
      S_DATA: begin
        w_active   = 1'b1;
        w_shift_en = w_decide;
      end
      S_PARITY: begin
        w_active    = 1'b1;
        w_parity_en = w_decide;
      end
      S_STOP: begin
        w_active = 1'b1;
        w_commit = w_decide;
      end
      default: ;
    endcase
  end

  assign w_ferr = (w_rx_bit != UART_STOP);

  // ---------------------------------------------------------------------------
  // Bit timing counter: held at 0 outside a frame, wraps at each bit centre
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt <= '0;
    end else if (!w_active || w_tick) begin
      r_clk_cnt <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------------
  // NOTE: the shift register is an ordinary register, not a memory, and is
  // reset like the counters so a read straight after reset returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
    end else begin
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      // Shifting in from the top leaves the first bit in position 0 once all
      // WORD_LENGTH bits have arrived.
      if (w_shift_en) begin
        r_shift <= {w_rx_bit, r_shift[WORD_LENGTH-1:1]};
      end
      if (w_parity_en) begin
        r_perr <= w_rx_bit ^ even_parity(PARITY_MAX_WIDTH'(r_shift));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold-until-read output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_err_ack    <= 1'b0;
    end else begin
      r_err_ack <= 1'b0;
      if (w_commit) begin
        r_err_ack <= r_perr | w_ferr;
        // A read in the commit cycle frees the holding register, so the new
        // frame replaces the one being read instead of overrunning it.
        if (!r_valid || Rx_RD) begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_perr;
          r_frame_err  <= w_ferr;
          r_valid      <= 1'b1;
          r_overrun    <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (Rx_RD && r_valid) begin
        // The data word is left in place; only the status is consumed.
        r_valid      <= 1'b0;
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign Rx_DATA       = r_rx_data;
  assign Rx_VALID      = r_valid;
  assign Rx_PARITY_ERR = r_parity_err;
  assign Rx_FRAME_ERR  = r_frame_err;
  assign Rx_OVERRUN    = r_overrun;
  assign err_ack       = r_err_ack;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with CLKS_PER_BIT = 16, WORD_LENGTH = 8.
// Frames are driven onto the line bit by bit; the expected holding-register
// contents come from a frame-level model (deliver / overrun / read rules and
// parity by counting ones). err_ack pulses are counted on every falling edge
// and compared with the number of errored frames the model expects, which
// also catches pulses longer than one cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int WL  = 8;
  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DECIDE_LAG = 1;
`else
  localparam int DECIDE_LAG = 0;
`endif
  localparam int FRAME_CYC = 11 * CPB;
  // Edge (counted from the edge after which the start bit is driven) on which
  // a frame commits: 3 cycles to START, half a bit to the start centre, ten
  // more bits to the stop centre, then the commit edge itself.
  localparam int COMMIT_EDGE = 3 + CPB / 2 + 10 * CPB + DECIDE_LAG;

  logic          clk = 1'b0;
  logic          rst;
  logic          line;
  logic          rd;
  logic [WL-1:0] rx_data;
  logic          rx_valid;
  logic          rx_perr;
  logic          rx_ferr;
  logic          rx_ovr;
  logic          err_ack;

  uart_rx #(
    .WORD_LENGTH  (WL),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .UART_Rx_IN    (line),
    .Rx_DATA       (rx_data),
    .Rx_VALID      (rx_valid),
    .Rx_RD         (rd),
    .Rx_PARITY_ERR (rx_perr),
    .Rx_FRAME_ERR  (rx_ferr),
    .Rx_OVERRUN    (rx_ovr),
    .err_ack       (err_ack)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_fail   = 0;
  int ack_seen = 0;

  always @(negedge clk) begin
    if (err_ack === 1'b1) ack_seen++;
  end

  // ---------------------------------------------------------------------------
  // Frame-level reference model
  // ---------------------------------------------------------------------------
  logic [WL-1:0] m_data;
  logic          m_valid, m_perr, m_ferr, m_ovr;
  int            m_acks;

  task automatic model_reset();
    m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic model_frame(input logic [WL-1:0] d, input logic par,
                             input logic stp, input bit rd_commit);
    logic perr, ferr;
    perr = (par != logic'($countones(d) % 2));
    ferr = (stp == 1'b0);
    if (!m_valid || rd_commit) begin
      m_data = d; m_perr = perr; m_ferr = ferr; m_valid = 1; m_ovr = 0;
    end else begin
      m_ovr = 1;
    end
    if (perr || ferr) m_acks++;
  endtask

  task automatic model_read();
    if (m_valid) begin
      m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},    32'(rx_data),  32'(m_data));
    check({tag, ".valid"},   32'(rx_valid), 32'(m_valid));
    check({tag, ".perr"},    32'(rx_perr),  32'(m_perr));
    check({tag, ".ferr"},    32'(rx_ferr),  32'(m_ferr));
    check({tag, ".overrun"}, 32'(rx_ovr),   32'(m_ovr));
    check({tag, ".acks"},    32'(ack_seen), 32'(m_acks));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      line = 1'b1;
      rd   = 1'b0;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one full frame. spike_at inverts the line for one cycle at that
  // cycle index; abort_at stops driving at that cycle index (-1 = never).
  // The line is left at the stop-bit level when the task returns.
  task automatic send_frame(input logic [WL-1:0] d, input logic par, input logic stp,
                            input bit rd_commit, input int spike_at, input int abort_at);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) return;
      line = bits[4'(c / CPB)] ^ logic'(c == spike_at);
      rd   = logic'(rd_commit && (c == COMMIT_EDGE - 1));
    end
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic do_read(input string tag);
    @(posedge clk); #1;
    rd = 1'b1;
    @(negedge clk);
    check({tag, ".valid_before_rd"}, 32'(rx_valid), 32'(m_valid));
    @(posedge clk); #1;
    rd = 1'b0;
    model_read();
    @(negedge clk);
    check_all({tag, ".after_rd"});
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [WL-1:0] d;
    logic          par, stp;
    bit            rdc;

    m_acks = 0;
    model_reset();
    rst  = 1'b1;
    line = 1'b1;
    rd   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    check("reset.err_ack", 32'(err_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(CPB);
    @(negedge clk);
    check_all("post_reset_idle");

    // Good frame
    send_frame(8'hA5, 1'b0, 1'b1, 0, -1, -1);
    model_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(4);
    @(negedge clk);
    check_all("good_a5");
    do_read("good_a5");
    do_read("rd_when_empty");

    // Parity error
    send_frame(8'h01, 1'b0, 1'b1, 0, -1, -1);
    model_frame(8'h01, 1'b0, 1'b1, 0);
    idle(4);
    @(negedge clk);
    check_all("parity_01");
    do_read("parity_01");

    // Framing error followed by a break of 40 clk
    send_frame(8'h3C, 1'b0, 1'b0, 0, -1, -1);
    model_frame(8'h3C, 1'b0, 1'b0, 0);
    hold(4);
    @(negedge clk);
    check_all("frame_3c");
    do_read("frame_3c");
    hold(32);
    @(negedge clk);
    check_all("break_hold");
    idle(CPB);
    send_frame(8'h55, 1'b0, 1'b1, 0, -1, -1);
    model_frame(8'h55, 1'b0, 1'b1, 0);
    idle(4);
    @(negedge clk);
    check_all("after_break_55");
    do_read("after_break_55");

    // 5-clk glitch on an idle line
    @(posedge clk); #1;
    line = 1'b0;
    hold(5);
    line = 1'b1;
    idle(3 * CPB);
    @(negedge clk);
    check_all("glitch");

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle spike at the centre of data bit 2 of 0xF0
    send_frame(8'hF0, 1'b0, 1'b1, 0, 3 * CPB + CPB / 2, -1);
    model_frame(8'hF0, 1'b0, 1'b1, 0);
    idle(4);
    @(negedge clk);
    check_all("spike_f0");
    do_read("spike_f0");
`endif

    // Overrun without a read
    send_frame(8'h11, 1'b0, 1'b1, 0, -1, -1);
    model_frame(8'h11, 1'b0, 1'b1, 0);
    idle(4);
    send_frame(8'h22, 1'b0, 1'b1, 0, -1, -1);
    model_frame(8'h22, 1'b0, 1'b1, 0);
    idle(4);
    @(negedge clk);
    check_all("overrun");
    do_read("overrun");

    // Read in the commit cycle of the second frame
    send_frame(8'h11, 1'b0, 1'b1, 0, -1, -1);
    model_frame(8'h11, 1'b0, 1'b1, 0);
    idle(4);
    send_frame(8'h22, 1'b0, 1'b1, 1, -1, -1);
    model_frame(8'h22, 1'b0, 1'b1, 1);
    idle(4);
    @(negedge clk);
    check_all("rd_at_commit");

    // Reset during data bit 4 of 0x99, with a frame still held
    send_frame(8'h99, 1'b0, 1'b1, 0, -1, 5 * CPB + CPB / 2);
    rst  = 1'b1;
    line = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("mid_reset");
    check("mid_reset.err_ack", 32'(err_ack), 32'd0);
    hold(3);
    rst = 1'b0;
    idle(CPB);
    send_frame(8'h66, 1'b0, 1'b1, 0, -1, -1);
    model_frame(8'h66, 1'b0, 1'b1, 0);
    idle(4);
    @(negedge clk);
    check_all("after_reset_66");
    do_read("after_reset_66");

    // Random frames: random data, occasional parity/stop errors, random reads
    for (int i = 0; i < 12; i++) begin
      d   = WL'($urandom);
      par = logic'($countones(d) % 2) ^ logic'($urandom_range(0, 3) == 0);
      stp = logic'($urandom_range(0, 5) != 0);
      rdc = ($urandom_range(0, 3) == 0);
      send_frame(d, par, stp, rdc, -1, -1);
      model_frame(d, par, stp, rdc);
      idle(CPB);
      @(negedge clk);
      check_all($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) do_read($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver for the UART link: the mirror of the transmitter on the same line.
- Frame format: start bit (0), `WORD_LENGTH` data bits LSB first, one even-parity bit (parity bit = XOR of the data bits), stop bit (1).
- Recovers bit timing from the start-bit edge and samples each bit at its centre.
- Presents received words and error status to the APB side with a hold-until-read handshake, and raises `err_ack` toward the transmitter on corrupted frames.

## Interface
Parameters:
- `WORD_LENGTH`, 8, number of data bits per frame.
- `CLKS_PER_BIT`, 434, clk cycles per bit (clock rate / baud). Must be ≥ 4, or ≥ 8 with `UART_RX_MAJORITY_VOTE_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `UART_Rx_IN`  in  1  asynchronous serial line, idles high.
- `Rx_DATA`  out  `WORD_LENGTH`  last received word.
- `Rx_VALID`  out  1  `Rx_DATA` and the error flags hold an unread frame.
- `Rx_RD`  in  1  one-cycle read strobe from APB; consumes the frame.
- `Rx_PARITY_ERR`  out  1  parity mismatch on the held frame.
- `Rx_FRAME_ERR`  out  1  stop bit sampled as 0 on the held frame.
- `Rx_OVERRUN`  out  1  a frame was lost because `Rx_VALID` was still set.
- `err_ack`  out  1  one-cycle pulse to the transmitter on a parity or framing error.

## Operation
- `UART_Rx_IN` passes through a 2-flop synchronizer. All logic uses the synchronized bit `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. Reset state is IDLE.
- **IDLE:** a 1→0 transition on `rx_s` clears the bit counter and enters START.
- **START:** sample when the bit counter reaches `CLKS_PER_BIT/2 - 1`.
  - Sample 0: clear the counter and go to DATA.
  - Sample 1: false start; return to IDLE. No outputs change.
- **DATA:** sample each time the counter reaches `CLKS_PER_BIT - 1`. The counter wraps to 0 on each sample.
  - Bit `i` is stored in shift register position `i` (LSB first).
  - After `WORD_LENGTH` samples, go to PARITY.
- **PARITY:** one sample. Compute `perr = sample XOR (^data)`. Go to STOP.
- **STOP:** one sample. Set `ferr` = (sample == 0), then commit the frame:
  - If `Rx_VALID == 0` or `Rx_RD == 1` in the commit cycle: load `Rx_DATA`, `Rx_PARITY_ERR = perr`, `Rx_FRAME_ERR = ferr`, and set `Rx_VALID = 1`.
  - Otherwise: discard the frame and set `Rx_OVERRUN = 1`. The held data and flags are unchanged.
  - Pulse `err_ack` if `perr | ferr`, including on overrun.
  - Next state: IDLE if the stop sample is 1, else BREAK_WAIT.
- **BREAK_WAIT:** stay until `rx_s == 1`, then go to IDLE. No new start bit is detected during a break.
- `Rx_RD` while `Rx_VALID == 1` (and no commit in the same cycle): clear `Rx_VALID`, `Rx_PARITY_ERR`, `Rx_FRAME_ERR`, `Rx_OVERRUN` on the next edge. `Rx_DATA` keeps its value.
- `Rx_RD` while `Rx_VALID == 0`: ignored.
- Width rules:
  - Bit counter: `$clog2(CLKS_PER_BIT)` bits.
  - Data counter: `$clog2(WORD_LENGTH+1)` bits.
- Frames with errors are still delivered; software decides whether to discard them.

## Timing
- Reset values: every output is 0. FSM is IDLE; counters and shift register are 0.
- Reset asserted mid-frame aborts the frame immediately with no commit.
- Latency from line falling edge to START entry: 3 clk (2 synchronizer flops + edge detect).
- Commit: `Rx_VALID`, data and flags update on the clk edge after the stop-bit sample. `err_ack` is high for exactly that one cycle.
- Back-to-back frames: IDLE is re-entered the cycle after commit. A start edge arriving at half-stop-bit is therefore caught.
- `Rx_VALID` stays high until `Rx_RD`. There is no timeout.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - Every bit, including the start bit, is the 2-of-3 majority of samples at counter values centre-1, centre, centre+1.
  - The decision is taken at centre+1. The next bit's centre is still referenced to the same counter, so the bit period is unchanged.
- Not defined: a single sample at centre.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `rx_state_t`.
  - `UART_IDLE` / `UART_START` / `UART_STOP` line levels.
  - Parity helper function (even XOR), shared with the transmitter.
- Sub-module `uart_rx_sync`: the 2-flop synchronizer plus falling-edge detector. It also holds the three-sample majority voter when the macro is enabled.
- FSM, counters and the output register stay in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT = 16`, `WORD_LENGTH = 8`.
- **Good frame:** 0xA5 with parity 0, stop 1 → `Rx_DATA = 0xA5`, `Rx_VALID = 1`, both error flags 0, no `err_ack`. `Rx_RD` then clears `Rx_VALID` the next cycle.
- **Parity error:** 0x01 with parity bit 0 → `Rx_DATA = 0x01`, `Rx_PARITY_ERR = 1`, a one-cycle `err_ack`.
- **Framing error / break:** 0x3C with stop 0 and the line held low for 40 clk → `Rx_FRAME_ERR = 1`, `err_ack` pulse. No new frame is accepted until the line rises; the next 0x55 frame is received correctly.
- **Overrun:** two frames 0x11 then 0x22 with no `Rx_RD` → `Rx_DATA = 0x11`, `Rx_OVERRUN = 1`.
  - Repeat with `Rx_RD` in the second commit cycle → `Rx_DATA = 0x22`, `Rx_OVERRUN = 0`.
- **Glitch:** a 5-clk low pulse on an idle line → FSM returns to IDLE and `Rx_VALID` stays 0.
  - With `UART_RX_MAJORITY_VOTE_EN`: a 1-clk spike at a data-bit centre of 0xF0 → still `Rx_DATA = 0xF0`.
- **Reset mid-frame:** assert `rst` during bit 4 of 0x99 → all outputs 0. The next full 0x66 frame is received correctly.
